// File: rtl/icache_assoc.sv
// Set-associative instruction cache with true-LRU ages and multi-word block fill.
// Hits return in the same cycle; a miss stalls until the fill is done (BLOCK_WORDS+1 cycles with no iwait).
module icache_assoc #(
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iflush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int OB = $clog2(BLOCK_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TB = 30 - OB - IB;
  localparam int OW = (OB > 0) ? OB : 1;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FILL} state_t;
  state_t state, next_state;

  logic          valid [SETS][WAYS];
  logic [TB-1:0] tags  [SETS][WAYS];
  logic [31:0]   data  [SETS][WAYS][BLOCK_WORDS];
  logic [WW-1:0] age   [SETS][WAYS];

  logic [31:0]   base;
  logic [WW-1:0] victim;
  logic [OW-1:0] wcnt;
  logic          flush_pending;

  logic [IB-1:0] req_idx, fill_idx, upd_idx;
  logic [OW-1:0] req_off;
  logic [TB-1:0] req_tag, fill_tag;
  logic [WW-1:0] hit_way, vic_way, upd_way;
  logic          hit_any, fill_last, fill_done, miss_start, upd_en, clear_all;

  assign req_idx  = IB'(imemaddr >> (OB + 2));
  assign req_off  = OW'((imemaddr >> 2) & 32'(BLOCK_WORDS - 1));
  assign req_tag  = TB'(imemaddr >> (OB + IB + 2));
  assign fill_idx = IB'(base >> (OB + 2));
  assign fill_tag = TB'(base >> (OB + IB + 2));

  assign fill_last  = (wcnt == OW'(BLOCK_WORDS - 1));
  assign fill_done  = (state == FILL) && !iwait && fill_last;
  assign miss_start = (state == IDLE) && imemREN && !iflush && !hit_any;
  assign clear_all  = ((state == IDLE) && iflush) || (fill_done && (flush_pending || iflush));

  // Lowest invalid way wins the victim choice; otherwise the oldest way.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    vic_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[req_idx][w] == WW'(WAYS - 1)) vic_way = WW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[req_idx][w]) vic_way = WW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WW'(w);
      end
  end

  always_comb begin
    upd_en  = 1'b0;
    upd_idx = req_idx;
    upd_way = hit_way;
    if ((state == IDLE) && imemREN && !iflush && hit_any) begin
      upd_en = 1'b1;
    end else if (fill_done) begin
      upd_en  = 1'b1;
      upd_idx = fill_idx;
      upd_way = victim;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Outputs are forced low while nRST is asserted, even mid-fill.
  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    case (state)
      IDLE: begin
        ihit = nRST && imemREN && !iflush && hit_any;
        if (ihit) imemload = data[req_idx][hit_way][req_off];
        if (miss_start) next_state = FILL;
      end
      FILL: begin
        iREN = nRST;
        if (nRST) iaddr = base + (32'(wcnt) << 2);
        if (fill_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid[s][w] <= 1'b0;
          age[s][w]   <= WW'(w);
        end
      base          <= '0;
      victim        <= '0;
      wcnt          <= '0;
      flush_pending <= 1'b0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      if (upd_en)
        for (int w = 0; w < WAYS; w++)
          if (WW'(w) == upd_way)
            age[upd_idx][w] <= '0;
          else if (age[upd_idx][w] < age[upd_idx][upd_way])
            age[upd_idx][w] <= age[upd_idx][w] + 1'b1;
      if (ihit) hit_count <= hit_count + 32'd1;
      if (miss_start) begin
        base       <= imemaddr & ~32'(BLOCK_WORDS * 4 - 1);
        victim     <= vic_way;
        wcnt       <= '0;
        miss_count <= miss_count + 32'd1;
      end
      if ((state == FILL) && iflush) flush_pending <= 1'b1;
      if ((state == FILL) && !iwait) wcnt <= wcnt + 1'b1;
      if (fill_done) begin
        valid[fill_idx][victim] <= 1'b1;
        flush_pending           <= 1'b0;
      end
      // A pending flush also wipes the line that just completed.
      if (clear_all)
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            valid[s][w] <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if ((state == FILL) && !iwait) begin
      data[fill_idx][victim][wcnt] <= iload;
      if (fill_last) tags[fill_idx][victim] <= fill_tag;
    end
  end

endmodule
